// File: rtl/adder_share_arb_if.sv
// adder_share_arb_if: request/response bundle between two clients and the shared adder arbiter
interface adder_share_arb_if #(parameter int WIDTH = 8);
  logic             in_valid0, in_valid1;
  logic             in_ready0, in_ready1;
  logic [WIDTH-1:0] A0, B0, A1, B1;
  logic             Cin0, Cin1;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] S;
  logic             Cout, V;
  modport slave (
    input  in_valid0, in_valid1, A0, B0, A1, B1, Cin0, Cin1, rsp_ready,
    output in_ready0, in_ready1, rsp_valid, rsp_id, S, Cout, V
  );
  modport master (
    output in_valid0, in_valid1, A0, B0, A1, B1, Cin0, Cin1, rsp_ready,
    input  in_ready0, in_ready1, rsp_valid, rsp_id, S, Cout, V
  );
endinterface

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sharing of one ripple-carry adder between two requesters
module adder_share_arb #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  adder_share_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t           state, state_n;
  logic             prio, id, op_cin, rv, cout_r, v_r;
  logic [WIDTH-1:0] op_a, op_b, s_r, sum;
  logic [WIDTH:0]   c;
  logic             gid, acc;
  assign gid = (prio ? bus.in_valid1 : bus.in_valid0) ? prio : ~prio;
  assign c[0] = op_cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = op_a[i] ^ op_b[i] ^ c[i];
    assign c[i+1]   = (op_a[i] & op_b[i]) | (c[i] & (op_a[i] ^ op_b[i]));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (acc ? CALC : IDLE) :
              state == CALC ? RESP :
              (bus.rsp_ready ? IDLE : RESP);
  end
  // in_ready is held low while in reset even though state already reads IDLE
  always_comb begin
    acc           = rst_n && state == IDLE && (bus.in_valid0 || bus.in_valid1);
    bus.in_ready0 = acc && !gid;
    bus.in_ready1 = acc && gid;
    bus.rsp_valid = rv;
    bus.rsp_id    = id;
    bus.S         = s_r;
    bus.Cout      = cout_r;
    bus.V         = v_r;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio   <= 1'b0;
      id     <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
      s_r    <= '0;
      cout_r <= 1'b0;
      v_r    <= 1'b0;
      rv     <= 1'b0;
    end else if (acc) begin
      prio   <= ~gid;
      id     <= gid;
      op_a   <= gid ? bus.A1 : bus.A0;
      op_b   <= gid ? bus.B1 : bus.B0;
      op_cin <= gid ? bus.Cin1 : bus.Cin0;
    end else if (state == CALC) begin
      s_r    <= sum;
      cout_r <= c[WIDTH];
      v_r    <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      rv     <= 1'b1;
    end else if (state == RESP && bus.rsp_ready) begin
      rv     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: random and directed traffic checked against a transaction-level model
module tb_adder_share_arb;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  adder_share_arb_if #(.WIDTH(W)) bus ();
  adder_share_arb #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: a client-visible view of the block (busy phase, priority, pending result)
  int         m_phase;
  logic       m_prio, e_valid, e_id, e_c, e_v;
  logic [W-1:0] e_s;
  always @(negedge clk) begin
    int k;
    logic [W:0] t;
    if (!rst_n) begin
      m_phase = 0; m_prio = 0; e_valid = 0; e_id = 0; e_s = 0; e_c = 0; e_v = 0;
    end else begin
      k = -1;
      if (m_phase == 0) begin
        if (m_prio == 0) k = bus.in_valid0 ? 0 : (bus.in_valid1 ? 1 : -1);
        else             k = bus.in_valid1 ? 1 : (bus.in_valid0 ? 0 : -1);
      end
      chk("in_ready0", bus.in_ready0, k == 0);
      chk("in_ready1", bus.in_ready1, k == 1);
      chk("rsp_valid", bus.rsp_valid, e_valid);
      if (e_valid) begin
        chk("rsp_id", bus.rsp_id, e_id);
        chk("S", bus.S, e_s);
        chk("Cout", bus.Cout, e_c);
        chk("V", bus.V, e_v);
      end
      if (k >= 0) begin
        logic [W-1:0] a, b;
        a = k ? bus.A1 : bus.A0;
        b = k ? bus.B1 : bus.B0;
        t = a + b + (k ? bus.Cin1 : bus.Cin0);
        e_s = t[W-1:0]; e_c = t[W];
        e_v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        e_id = k[0]; m_prio = ~k[0]; m_phase = 1;
      end else if (m_phase == 1) begin
        e_valid = 1; m_phase = 2;
      end else if (m_phase == 2 && bus.rsp_ready) begin
        e_valid = 0; m_phase = 0;
      end
    end
  end

  task automatic drive(input logic v0, input logic [W-1:0] a0, b0, input logic c0,
                       input logic v1, input logic [W-1:0] a1, b1, input logic c1,
                       input logic rr, input int cyc);
    bus.in_valid0 = v0; bus.A0 = a0; bus.B0 = b0; bus.Cin0 = c0;
    bus.in_valid1 = v1; bus.A1 = a1; bus.B1 = b1; bus.Cin1 = c1;
    bus.rsp_ready = rr;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy0"}, bus.in_ready0, 0);
    chk({tag, "_rdy1"}, bus.in_ready1, 0);
    chk({tag, "_rv"}, bus.rsp_valid, 0);
    chk({tag, "_id"}, bus.rsp_id, 0);
    chk({tag, "_S"}, bus.S, 0);
    chk({tag, "_Cout"}, bus.Cout, 0);
    chk({tag, "_V"}, bus.V, 0);
  endtask

  initial begin
    bus.in_valid0 = 1; bus.in_valid1 = 1; bus.A0 = 0; bus.B0 = 0; bus.Cin0 = 0;
    bus.A1 = 0; bus.B1 = 0; bus.Cin1 = 0; bus.rsp_ready = 1;
    #1 chk_zero("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // overflow then wrap-around
    drive(1, 8'h7F, 8'h01, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 8'h7F, 8'h01, 0, 0, 0, 0, 0, 1, 4);
    drive(0, 0, 0, 0, 1, 8'hFF, 8'h00, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 8'hFF, 8'h00, 1, 1, 4);
    // contention then backpressure
    drive(1, 8'h05, 8'h03, 0, 1, 8'h80, 8'h80, 0, 1, 12);
    drive(1, 8'h05, 8'h03, 0, 1, 8'h80, 8'h80, 0, 0, 5);
    drive(1, 8'h05, 8'h03, 0, 1, 8'h80, 8'h80, 0, 1, 6);
    // operand isolation: A0 changes right after the accept edge
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    drive(1, 8'h10, 8'h20, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 8'hAA, 8'h20, 0, 0, 0, 0, 0, 1, 4);
    // reset in the middle of CALC with both requesters pending
    drive(1, 8'h11, 8'h22, 1, 0, 0, 0, 0, 1, 1);
    bus.in_valid1 = 1;
    #1 rst_n = 0;
    #1 chk_zero("rst_calc");
    @(posedge clk);
    #1 chk_zero("rst_hold");
    rst_n = 1;
    #1 chk("first_grant0", bus.in_ready0, 1);
    drive(1, 8'h01, 8'h02, 0, 1, 8'h03, 8'h04, 1, 1, 8);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1),
            $urandom_range(0, 3) != 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
